// File: rtl/mem_signature_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : mem_signature_monitor
//  Purpose  : End-of-program monitor; checks signature writes, fetch validity
//             and a watchdog, and latches sticky pass/fail status.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_signature_monitor #(
  parameter int XLEN           = 32,
  parameter int NUM_CHECKS     = 4,
  parameter int ORDERED        = 1,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_en,
  input  logic                       mem_we,
  input  logic [XLEN-1:0]            mem_addr,
  input  logic [XLEN-1:0]            mem_wdata,
  input  logic                       fetch_valid,
  input  logic [NUM_CHECKS*XLEN-1:0] exp_addr,
  input  logic [NUM_CHECKS*XLEN-1:0] exp_data,
  output logic                       done,
  output logic                       pass,
  output logic [2:0]                 fail_code,
  output logic [$clog2(NUM_CHECKS):0] fail_index,
  output logic [XLEN-1:0]            fail_data,
  output logic [NUM_CHECKS-1:0]      hit_mask,
  output logic [CNT_W-1:0]           cycles
);

  localparam int IDX_W = $clog2(NUM_CHECKS) + 1;

  localparam logic [2:0] c_CODE_NONE     = 3'd0;
  localparam logic [2:0] c_CODE_MISMATCH = 3'd1;
  localparam logic [2:0] c_CODE_ORDER    = 3'd2;
  localparam logic [2:0] c_CODE_NO_INSTR = 3'd3;
  localparam logic [2:0] c_CODE_TIMEOUT  = 3'd4;

  localparam logic [NUM_CHECKS-1:0] c_ONE          = NUM_CHECKS'(1);
  localparam logic [CNT_W-1:0]      c_CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]      c_CNT_MAX      = '1;
  localparam logic [CNT_W-1:0]      c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit                    c_WDOG_EN      = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_done;
  logic                  r_pass;
  logic [2:0]            r_fail_code;
  logic [IDX_W-1:0]      r_fail_index;
  logic [XLEN-1:0]       r_fail_data;
  logic [NUM_CHECKS-1:0] r_hit_mask;
  logic [CNT_W-1:0]      r_cycles;

  state_t                w_state_nxt;
  logic                  w_done_nxt;
  logic                  w_pass_nxt;
  logic [2:0]            w_fail_code_nxt;
  logic [IDX_W-1:0]      w_fail_index_nxt;
  logic [XLEN-1:0]       w_fail_data_nxt;
  logic [NUM_CHECKS-1:0] w_hit_mask_nxt;
  logic [CNT_W-1:0]      w_cycles_nxt;

  logic                  w_wr;
  logic [NUM_CHECKS-1:0] w_unhit;
  logic [NUM_CHECKS-1:0] w_addr_hit;
  logic [NUM_CHECKS-1:0] w_data_ok;
  logic [NUM_CHECKS-1:0] w_set_oh;
  logic                  w_err;
  logic [2:0]            w_err_code;
  logic [IDX_W-1:0]      w_err_idx;
  logic                  w_timeout;

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [NUM_CHECKS-1:0] f_lowest(input logic [NUM_CHECKS-1:0] v);
    return v & (~v + c_ONE);
  endfunction

  function automatic logic [IDX_W-1:0] f_enc(input logic [NUM_CHECKS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign w_wr      = mem_en & mem_we;
  assign w_unhit   = ~r_hit_mask;
  assign w_timeout = c_WDOG_EN && (r_cycles == c_TIMEOUT_LAST);

  for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_entry
    assign w_addr_hit[gi] = (mem_addr  == exp_addr[gi*XLEN +: XLEN]);
    assign w_data_ok[gi]  = (mem_wdata == exp_data[gi*XLEN +: XLEN]);
  end

  if (ORDERED != 0) begin : g_ordered
    logic [NUM_CHECKS-1:0] w_ptr_oh;
    logic [NUM_CHECKS-1:0] w_later_oh;
    logic                  w_ptr_addr;
    logic                  w_ptr_good;

    // Every unhit entry other than the pointer lies above it.
    assign w_ptr_oh   = f_lowest(w_unhit);
    assign w_ptr_addr = |(w_ptr_oh & w_addr_hit);
    assign w_ptr_good = |(w_ptr_oh & w_addr_hit & w_data_ok);
    assign w_later_oh = f_lowest(w_addr_hit & w_unhit & ~w_ptr_oh);
    assign w_set_oh   = (w_wr && w_ptr_good) ? w_ptr_oh : '0;

    always_comb begin
      w_err      = 1'b0;
      w_err_code = c_CODE_NONE;
      w_err_idx  = '0;
      if (w_wr && w_ptr_addr && !w_ptr_good) begin
        w_err      = 1'b1;
        w_err_code = c_CODE_MISMATCH;
        w_err_idx  = f_enc(w_ptr_oh);
      end else if (w_wr && !w_ptr_addr && (|w_later_oh)) begin
        w_err      = 1'b1;
        w_err_code = c_CODE_ORDER;
        w_err_idx  = f_enc(w_later_oh);
      end
    end
  end else begin : g_unordered
    logic [NUM_CHECKS-1:0] w_cand_oh;
    logic                  w_cand_good;

    assign w_cand_oh   = f_lowest(w_addr_hit & w_unhit);
    assign w_cand_good = |(w_cand_oh & w_data_ok);
    assign w_set_oh    = (w_wr && w_cand_good) ? w_cand_oh : '0;
    assign w_err       = w_wr && (|w_cand_oh) && !w_cand_good;
    assign w_err_code  = w_err ? c_CODE_MISMATCH : c_CODE_NONE;
    assign w_err_idx   = f_enc(w_cand_oh);
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_done_nxt       = r_done;
    w_pass_nxt       = r_pass;
    w_fail_code_nxt  = r_fail_code;
    w_fail_index_nxt = r_fail_index;
    w_fail_data_nxt  = r_fail_data;
    w_hit_mask_nxt   = r_hit_mask;
    w_cycles_nxt     = r_cycles;

    if (r_state == ST_RUN) begin
      w_cycles_nxt   = (r_cycles == c_CNT_MAX) ? r_cycles : r_cycles + c_CNT_ONE;
      w_hit_mask_nxt = r_hit_mask | w_set_oh;

      // Priority: data/order error, completion, missing fetch, watchdog.
      if (w_err) begin
        w_state_nxt      = ST_FAIL;
        w_done_nxt       = 1'b1;
        w_pass_nxt       = 1'b0;
        w_fail_code_nxt  = w_err_code;
        w_fail_index_nxt = w_err_idx;
        w_fail_data_nxt  = mem_wdata;
      end else if (&w_hit_mask_nxt) begin
        w_state_nxt = ST_PASS;
        w_done_nxt  = 1'b1;
        w_pass_nxt  = 1'b1;
      end else if (!fetch_valid) begin
        w_state_nxt      = ST_FAIL;
        w_done_nxt       = 1'b1;
        w_pass_nxt       = 1'b0;
        w_fail_code_nxt  = c_CODE_NO_INSTR;
        w_fail_index_nxt = '0;
        w_fail_data_nxt  = '0;
      end else if (w_timeout) begin
        w_state_nxt      = ST_FAIL;
        w_done_nxt       = 1'b1;
        w_pass_nxt       = 1'b0;
        w_fail_code_nxt  = c_CODE_TIMEOUT;
        w_fail_index_nxt = '0;
        w_fail_data_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_code  <= c_CODE_NONE;
      r_fail_index <= '0;
      r_fail_data  <= '0;
      r_hit_mask   <= '0;
      r_cycles     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_fail_code  <= w_fail_code_nxt;
      r_fail_index <= w_fail_index_nxt;
      r_fail_data  <= w_fail_data_nxt;
      r_hit_mask   <= w_hit_mask_nxt;
      r_cycles     <= w_cycles_nxt;
    end
  end

  assign done       = r_done;
  assign pass       = r_pass;
  assign fail_code  = r_fail_code;
  assign fail_index = r_fail_index;
  assign fail_data  = r_fail_data;
  assign hit_mask   = r_hit_mask;
  assign cycles     = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_mem_signature_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_signature_monitor
//  Purpose  : Scoreboard bench for mem_signature_monitor (three configurations).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_signature_monitor;

  localparam logic [127:0] EA4 = {32'h1C, 32'h18, 32'h14, 32'h10};
  localparam logic [127:0] ED4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

  typedef struct packed {
    logic        done;
    logic        pass;
    logic [2:0]  code;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [3:0]  hit;
    logic [31:0] cyc;
  } exp_t;

  typedef struct {
    exp_t  v;
    string name;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        en    [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdat  [3];
  logic        fv    [3];
  logic        probe [3];

  logic        a_done, a_pass;
  logic [2:0]  a_code;
  logic [0:0]  a_idx;
  logic [31:0] a_data;
  logic [0:0]  a_hit;
  logic [31:0] a_cyc;
  logic        b_done, b_pass;
  logic [2:0]  b_code;
  logic [2:0]  b_idx;
  logic [31:0] b_data;
  logic [3:0]  b_hit;
  logic [31:0] b_cyc;
  logic        c_done, c_pass;
  logic [2:0]  c_code;
  logic [2:0]  c_idx;
  logic [31:0] c_data;
  logic [3:0]  c_hit;
  logic [31:0] c_cyc;

  rec_t q0[$], q1[$], q2[$];
  int total = 0;
  int bad   = 0;

  mem_signature_monitor #(.XLEN(32), .NUM_CHECKS(1), .ORDERED(1), .TIMEOUT_CYCLES(100000), .CNT_W(32)) u_a (
    .clk(clk), .reset(rst[0]), .mem_en(en[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdat[0]), .fetch_valid(fv[0]), .exp_addr(32'h0000000C), .exp_data(32'h0000000F),
    .done(a_done), .pass(a_pass), .fail_code(a_code), .fail_index(a_idx),
    .fail_data(a_data), .hit_mask(a_hit), .cycles(a_cyc));

  mem_signature_monitor #(.XLEN(32), .NUM_CHECKS(4), .ORDERED(1), .TIMEOUT_CYCLES(50), .CNT_W(32)) u_o (
    .clk(clk), .reset(rst[1]), .mem_en(en[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdat[1]), .fetch_valid(fv[1]), .exp_addr(EA4), .exp_data(ED4),
    .done(b_done), .pass(b_pass), .fail_code(b_code), .fail_index(b_idx),
    .fail_data(b_data), .hit_mask(b_hit), .cycles(b_cyc));

  mem_signature_monitor #(.XLEN(32), .NUM_CHECKS(4), .ORDERED(0), .TIMEOUT_CYCLES(0), .CNT_W(32)) u_u (
    .clk(clk), .reset(rst[2]), .mem_en(en[2]), .mem_we(we[2]), .mem_addr(addr[2]),
    .mem_wdata(wdat[2]), .fetch_valid(fv[2]), .exp_addr(EA4), .exp_data(ED4),
    .done(c_done), .pass(c_pass), .fail_code(c_code), .fail_index(c_idx),
    .fail_data(c_data), .hit_mask(c_hit), .cycles(c_cyc));

  function automatic exp_t get_act(input int k);
    exp_t a;
    a = '0;
    case (k)
      0: begin
        a.done = a_done; a.pass = a_pass; a.code = a_code; a.idx = 5'(a_idx);
        a.data = a_data; a.hit = 4'(a_hit); a.cyc = a_cyc;
      end
      1: begin
        a.done = b_done; a.pass = b_pass; a.code = b_code; a.idx = 5'(b_idx);
        a.data = b_data; a.hit = b_hit; a.cyc = b_cyc;
      end
      default: begin
        a.done = c_done; a.pass = c_pass; a.code = c_code; a.idx = 5'(c_idx);
        a.data = c_data; a.hit = c_hit; a.cyc = c_cyc;
      end
    endcase
    return a;
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic rec_t qpop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int k, input rec_t r);
    case (k)
      0:       q0.push_back(r);
      1:       q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endtask

  task automatic expect_out(input int k, input string nm, input bit d, input bit p,
                            input int code, input int idx, input logic [31:0] data,
                            input logic [3:0] hit, input int cyc);
    rec_t r;
    r.name   = nm;
    r.v.done = d;
    r.v.pass = p;
    r.v.code = 3'(code);
    r.v.idx  = 5'(idx);
    r.v.data = data;
    r.v.hit  = hit;
    r.v.cyc  = 32'(cyc);
    qpush(k, r);
  endtask

  // Monitor: one comparison per new terminal status or per probe request.
  initial begin
    bit   prev [3];
    exp_t a;
    rec_t r;
    for (int i = 0; i < 3; i++) prev[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        a = get_act(k);
        if ((a.done === 1'b1 && !prev[k]) || probe[k] === 1'b1) begin
          total++;
          if (qsize(k) == 0) begin
            bad++;
            $display("FAIL unexpected_output dut%0d: got done=%0d code=%0d cyc=%0d, want no output",
                     k, a.done, a.code, a.cyc);
          end else begin
            r = qpop(k);
            if (a !== r.v) begin
              bad++;
              $display("FAIL %s dut%0d: got done=%0d pass=%0d code=%0d idx=%0d data=%h hit=%h cyc=%0d, want done=%0d pass=%0d code=%0d idx=%0d data=%h hit=%h cyc=%0d",
                       r.name, k, a.done, a.pass, a.code, a.idx, a.data, a.hit, a.cyc,
                       r.v.done, r.v.pass, r.v.code, r.v.idx, r.v.data, r.v.hit, r.v.cyc);
            end
          end
        end
        prev[k] = (a.done === 1'b1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b0;
    en[k]  = 1'b0;
    we[k]  = 1'b0;
    fv[k]  = 1'b1;
    step();
    rst[k] = 1'b1;
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d);
    en[k]   = 1'b1;
    we[k]   = 1'b1;
    addr[k] = a;
    wdat[k] = d;
    step();
    en[k]   = 1'b0;
    we[k]   = 1'b0;
  endtask

  task automatic do_probe(input int k);
    probe[k] = 1'b1;
    @(negedge clk);
    #1;
    probe[k] = 1'b0;
  endtask

  task automatic drain(input int k, input int budget);
    for (int i = 0; i < budget && qsize(k) != 0; i++) step();
    if (qsize(k) != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout dut%0d: got %0d pending, want 0 pending", k, qsize(k));
      while (qsize(k) != 0) void'(qpop(k));
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; en[k] = 1'b0; we[k] = 1'b0; addr[k] = '0;
      wdat[k] = '0; fv[k] = 1'b1; probe[k] = 1'b0;
    end
    idle(2);

    // Single-entry configuration
    do_reset(0);
    expect_out(0, "reset_a", 0, 0, 0, 0, 32'h0, 4'h0, 0);
    do_probe(0);
    expect_out(0, "single_pass", 1, 1, 0, 0, 32'h0, 4'h1, 20);
    idle(19);
    wr(0, 32'hC, 32'h0F);
    drain(0, 200);

    do_reset(0);
    expect_out(0, "single_mismatch", 1, 0, 1, 0, 32'h0E, 4'h0, 5);
    idle(4);
    wr(0, 32'hC, 32'h0E);
    drain(0, 200);
    for (int i = 0; i < 10; i++) wr(0, 32'hC, 32'h0F);
    expect_out(0, "fail_sticky", 1, 0, 1, 0, 32'h0E, 4'h0, 5);
    do_probe(0);

    // Ordered four-entry configuration, watchdog 50
    do_reset(1);
    expect_out(1, "reset_o", 0, 0, 0, 0, 32'h0, 4'h0, 0);
    do_probe(1);
    expect_out(1, "order_err", 1, 0, 2, 2, 32'hA2, 4'h1, 2);
    wr(1, 32'h10, 32'hA0);
    wr(1, 32'h18, 32'hA2);
    drain(1, 200);

    do_reset(1);
    expect_out(1, "no_instr", 1, 0, 3, 0, 32'h0, 4'h0, 7);
    idle(6);
    fv[1] = 1'b0;
    step();
    fv[1] = 1'b1;
    drain(1, 200);

    do_reset(1);
    expect_out(1, "timeout", 1, 0, 4, 0, 32'h0, 4'h0, 50);
    idle(50);
    drain(1, 200);

    do_reset(1);
    expect_out(1, "final_on_timeout", 1, 1, 0, 0, 32'h0, 4'hF, 50);
    wr(1, 32'h10, 32'hA0);
    wr(1, 32'h14, 32'hA1);
    wr(1, 32'h18, 32'hA2);
    idle(46);
    wr(1, 32'h1C, 32'hA3);
    drain(1, 200);

    do_reset(1);
    expect_out(1, "final_on_no_instr", 1, 1, 0, 0, 32'h0, 4'hF, 10);
    wr(1, 32'h10, 32'hA0);
    wr(1, 32'h14, 32'hA1);
    wr(1, 32'h18, 32'hA2);
    idle(6);
    fv[1] = 1'b0;
    wr(1, 32'h1C, 32'hA3);
    fv[1] = 1'b1;
    drain(1, 200);

    do_reset(1);
    expect_out(1, "mismatch_on_timeout", 1, 0, 1, 0, 32'hBAD, 4'h0, 50);
    idle(49);
    wr(1, 32'h10, 32'hBAD);
    drain(1, 200);

    do_reset(1);
    expect_out(1, "reset_from_fail", 0, 0, 0, 0, 32'h0, 4'h0, 0);
    do_probe(1);
    wr(1, 32'h10, 32'hA0);
    wr(1, 32'h14, 32'hA1);
    wr(1, 32'h10, 32'h77);
    wr(1, 32'h40, 32'h12);
    expect_out(1, "partial_hits", 0, 0, 0, 0, 32'h0, 4'h3, 4);
    do_probe(1);
    do_reset(1);
    expect_out(1, "reset_mid_seq", 0, 0, 0, 0, 32'h0, 4'h0, 0);
    do_probe(1);
    expect_out(1, "pass_after_reset", 1, 1, 0, 0, 32'h0, 4'hF, 4);
    wr(1, 32'h10, 32'hA0);
    wr(1, 32'h14, 32'hA1);
    wr(1, 32'h18, 32'hA2);
    wr(1, 32'h1C, 32'hA3);
    drain(1, 200);

    // Unordered four-entry configuration, watchdog disabled
    do_reset(2);
    expect_out(2, "unordered_pass", 1, 1, 0, 0, 32'h0, 4'hF, 4);
    wr(2, 32'h1C, 32'hA3);
    wr(2, 32'h10, 32'hA0);
    wr(2, 32'h18, 32'hA2);
    wr(2, 32'h14, 32'hA1);
    drain(2, 200);

    do_reset(2);
    idle(10000);
    expect_out(2, "no_watchdog", 0, 0, 0, 0, 32'h0, 4'h0, 10000);
    do_probe(2);

    do_reset(2);
    expect_out(2, "unordered_mismatch", 1, 0, 1, 1, 32'h55, 4'h0, 1);
    wr(2, 32'h14, 32'h55);
    drain(2, 200);

    idle(3);
    for (int k = 0; k < 3; k++) begin
      if (qsize(k) != 0) begin
        total++;
        bad++;
        $display("FAIL leftover dut%0d: got %0d pending, want 0 pending", k, qsize(k));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
